// File: rtl/usb_proto_engine.sv
// Host-side USB transaction engine: token, data, handshake, bounded retry.
// Optional macro USB_PROTO_STALL_EN: STALL ends the transaction at once.
module usb_proto_engine #(
  parameter int DATA_W  = 64,
  parameter int MAX_ERR = 8,
  parameter int TIMEOUT = 255,
  parameter int NUM_EP  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_dir,
  input  logic [6:0]        req_addr,
  input  logic [3:0]        req_endp,
  input  logic [DATA_W-1:0] req_data,
  input  logic              toggle_clr,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [3:0]        tx_pid,
  output logic [6:0]        tx_addr,
  output logic [3:0]        tx_endp,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_valid,
  input  logic              rx_ok,
  input  logic [3:0]        rx_pid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              done,
  output logic              success,
  output logic [DATA_W-1:0] rsp_data,
  output logic [3:0]        err_cnt
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] TOKEN     = 3'd1;
  localparam logic [2:0] DATA_TX   = 3'd2;
  localparam logic [2:0] HS_WAIT   = 3'd3;
  localparam logic [2:0] DATA_WAIT = 3'd4;
  localparam logic [2:0] HS_TX     = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

  logic [2:0]  state;
  logic [2:0]  hs_next;
  logic        dir;
  logic [15:0] timer;
  logic [15:0] tog;

  logic        ep_ok;
  logic        cur_tog;
  logic [3:0]  exp_pid;
  logic [3:0]  alt_pid;
  logic        tmo;
  logic        rx_good;
  logic        rx_stall;
  logic        hs_ack;
  logic        dat_ok;
  logic        dat_mis;
  logic        tog_flip;
  logic [3:0]  err_nxt;
  logic        err_last;

  // endpoints beyond the tracked range are pinned to DATA0
  assign ep_ok    = {1'b0, tx_endp} < 5'(NUM_EP);
  assign cur_tog  = ep_ok & tog[tx_endp];
  assign exp_pid  = cur_tog ? PID_DATA1 : PID_DATA0;
  assign alt_pid  = cur_tog ? PID_DATA0 : PID_DATA1;
  assign tmo      = timer == 16'(TIMEOUT - 1);
  assign rx_good  = rx_valid & rx_ok;
  assign hs_ack   = rx_good & (rx_pid == PID_ACK);
  assign dat_ok   = rx_good & (rx_pid == exp_pid);
  assign dat_mis  = rx_good & (rx_pid == alt_pid);
  assign err_nxt  = err_cnt + 4'd1;
  assign err_last = err_nxt == 4'(MAX_ERR);
  assign req_ready = state == IDLE;

`ifdef USB_PROTO_STALL_EN
  localparam logic [3:0] PID_STALL = 4'b1110;
  assign rx_stall = rx_good & (rx_pid == PID_STALL);
`else
  assign rx_stall = 1'b0;
`endif

  assign tog_flip = ((state == HS_WAIT) & hs_ack)
                  | ((state == DATA_WAIT) & dat_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tog <= '0;
    end else if (toggle_clr) begin
      tog <= '0;
    end else if (tog_flip && ep_ok) begin
      tog[tx_endp] <= ~tog[tx_endp];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hs_next  <= DONE;
      dir      <= 1'b0;
      timer    <= '0;
      tx_valid <= 1'b0;
      tx_pid   <= '0;
      tx_addr  <= '0;
      tx_endp  <= '0;
      tx_data  <= '0;
      done     <= 1'b0;
      success  <= 1'b0;
      rsp_data <= '0;
      err_cnt  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (req_valid) begin
          dir      <= req_dir;
          tx_addr  <= req_addr;
          tx_endp  <= req_endp;
          tx_data  <= req_data;
          err_cnt  <= '0;
          success  <= 1'b0;
          tx_valid <= 1'b1;
          tx_pid   <= req_dir ? PID_IN : PID_OUT;
          state    <= TOKEN;
        end
        TOKEN: if (tx_ready) begin
          if (dir) begin
            tx_valid <= 1'b0;
            timer    <= '0;
            state    <= DATA_WAIT;
          end else begin
            tx_pid <= exp_pid;
            state  <= DATA_TX;
          end
        end
        DATA_TX: if (tx_ready) begin
          tx_valid <= 1'b0;
          timer    <= '0;
          state    <= HS_WAIT;
        end
        HS_WAIT: begin
          timer <= timer + 16'd1;
          if (hs_ack) begin
            success <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else if (rx_stall) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (rx_valid || tmo) begin
            err_cnt <= err_nxt;
            if (err_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              tx_valid <= 1'b1;
              tx_pid   <= exp_pid;
              state    <= DATA_TX;
            end
          end
        end
        DATA_WAIT: begin
          timer <= timer + 16'd1;
          if (dat_ok) begin
            rsp_data <= rx_data;
            success  <= 1'b1;
            tx_valid <= 1'b1;
            tx_pid   <= PID_ACK;
            hs_next  <= DONE;
            state    <= HS_TX;
          end else if (rx_stall) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (rx_valid || tmo) begin
            err_cnt <= err_nxt;
            if (err_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else if (dat_mis) begin
              tx_valid <= 1'b1;
              tx_pid   <= PID_ACK;
              hs_next  <= TOKEN;
              state    <= HS_TX;
            end else if (rx_good) begin
              tx_valid <= 1'b1;
              tx_pid   <= PID_IN;
              state    <= TOKEN;
            end else begin
              tx_valid <= 1'b1;
              tx_pid   <= PID_NAK;
              hs_next  <= DATA_WAIT;
              state    <= HS_TX;
            end
          end
        end
        HS_TX: if (tx_ready) begin
          tx_valid <= 1'b0;
          timer    <= '0;
          state    <= hs_next;
          if (hs_next == DONE) done <= 1'b1;
          if (hs_next == TOKEN) begin
            tx_valid <= 1'b1;
            tx_pid   <= PID_IN;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
